// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J instruction fields into 32-bit words, tags each with an
// auto-incremented instruction-memory address and buffers them in a small FIFO.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int MEM_WORDS  = 256,
  parameter int START_ADDR = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        fn,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_fmt,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, FULL} state_t;

  state_t                    state_reg, state_next;
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  logic [ADDR_W-1:0]         addr_reg;
  logic                      err_fmt_reg;
  logic [ADDR_W+31:0]        fifo_mem [FIFO_DEPTH];

  logic [31:0]               word_enc;
  logic                      fmt_legal;
  logic                      accept, push, pop;
  logic [ADDR_W+31:0]        head;

  always_comb begin
    word_enc  = '0;
    fmt_legal = 1'b1;
    unique case (fmt)
      2'd0:    word_enc = {opcode, rs, rt, rd, shamt, fn};
      2'd1:    word_enc = {opcode, rs, rt, imm};
      2'd2:    word_enc = {opcode, target};
      default: fmt_legal = 1'b0;
    endcase
  end

  // start takes priority: it flushes the buffer, so same-cycle handshakes are void
  assign in_ready = (state_reg == STREAM) && (count_reg < DEPTH_CNT);
  assign accept   = in_valid && in_ready && !start;
  assign push     = accept && fmt_legal;
  assign pop      = (count_reg != '0) && out_ready && !start;

  always_comb begin
    state_next = state_reg;
    if (start)
      state_next = STREAM;
    else if (state_reg == STREAM && push && addr_reg == LAST_ADDR)
      state_next = FULL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      addr_reg    <= FIRST_ADDR;
      err_fmt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      err_fmt_reg <= accept && !fmt_legal;
      if (start) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        addr_reg   <= FIRST_ADDR;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          // the last address is held rather than wrapped
          if (addr_reg != LAST_ADDR)
            addr_reg <= addr_reg + 1'b1;
        end
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)
          count_reg <= count_reg + 1'b1;
        else if (pop && !push)
          count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {addr_reg, word_enc};
  end

  // Storage is not reset, so the head is masked until it holds a real entry
  assign head      = fifo_mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_word  = out_valid ? head[31:0] : 32'd0;
  assign out_addr  = out_valid ? head[ADDR_W+31:32] : '0;
  assign err_fmt   = err_fmt_reg;
  assign done      = (state_reg == FULL) && (count_reg == '0);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word memory so the FULL/done
// boundary is reached quickly; table vectors plus hand-written sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, out_valid, out_ready, err_fmt, done;
  logic [1:0]  fmt;
  logic [5:0]  opcode, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] out_word;
  logic [7:0]  out_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  vec_t bad_vec;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .MEM_WORDS(4), .START_ADDR(0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .fn(fn),
    .imm(imm), .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err_fmt(err_fmt), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else
      $display("ok   %s: 0x%08h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
    shamt = v.sh; fn = v.fn; imm = v.imm; target = v.tgt;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s: in_ready never rose, got 0 expected 1", name);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input vec_t v, input string name);
    drive(v);
    wait_accept(name);
  endtask

  task automatic pop_check(input logic [31:0] w, input logic [7:0] a, input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, " word"}, out_word, w);
    check({name, " addr"}, {24'd0, out_addr}, {24'd0, a});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd1, 6'h08, 5'd0,  5'd17, 5'd0,  5'd0, 6'h00, 16'h0005, 26'h0, 32'h20110005};
    vecs[1] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h00221820};
    vecs[2] = '{2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000};
    vecs[3] = '{2'd1, 6'h23, 5'd29, 5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFC, 26'h0, 32'h8FA8FFFC};
    vecs[4] = '{2'd0, 6'h00, 5'd0,  5'd9,  5'd10, 5'd4, 6'h00, 16'hFFFF, 26'h3FFFFFF, 32'h00095100};
    vecs[5] = '{2'd2, 6'h03, 5'd7,  5'd7,  5'd7,  5'd7, 6'h15, 16'h1234, 26'h3FFFFFF, 32'h0FFFFFFF};
    vecs[6] = '{2'd1, 6'h0F, 5'd0,  5'd1,  5'd0,  5'd0, 6'h00, 16'h1234, 26'h0, 32'h3C011234};
    vecs[7] = '{2'd0, 6'h3F, 5'd5,  5'd6,  5'd7,  5'd8, 6'h09, 16'h0000, 26'h0, 32'hFCA63A09};
    bad_vec = '{2'd3, 6'h11, 5'd1,  5'd1,  5'd1,  5'd1, 6'h01, 16'h1111, 26'h1, 32'h0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; fn = '0; imm = '0; target = '0;
    tick();
    tick();
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_word", out_word, 32'd0);
    check("reset out_addr", {24'd0, out_addr}, 32'd0);
    check("reset err_fmt", {31'd0, err_fmt}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    check("idle in_ready", {31'd0, in_ready}, 32'd0);
    check("idle out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;

    // table: 8 words in two groups of 4, each group filling the 4-word memory
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) begin
        pulse_start();
        check($sformatf("v%0d start done", i), {31'd0, done}, 32'd0);
        check($sformatf("v%0d start in_ready", i), {31'd0, in_ready}, 32'd1);
      end
      send(vecs[i], $sformatf("v%0d send", i));
      check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      pop_check(vecs[i].exp, 8'(i % 4), $sformatf("v%0d", i));
      if (i % 4 == 3) begin
        check($sformatf("v%0d full in_ready", i), {31'd0, in_ready}, 32'd0);
        check($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
      end
    end

    // FULL: further tuples are refused, no address wrap
    drive(vecs[0]);
    tick();
    tick();
    check("full no push", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;

    // backpressure: third tuple waits until a slot frees, order preserved
    pulse_start();
    check("restart done", {31'd0, done}, 32'd0);
    send(vecs[0], "bp send0");
    send(vecs[1], "bp send1");
    drive(vecs[2]);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp hold in_ready %0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp hold word %0d", k), out_word, vecs[0].exp);
      tick();
    end
    pop_check(vecs[0].exp, 8'd0, "bp pop0");
    wait_accept("bp send2");
    pop_check(vecs[1].exp, 8'd1, "bp pop1");
    pop_check(vecs[2].exp, 8'd2, "bp pop2");

    // illegal fmt between two legal tuples
    pulse_start();
    send(vecs[3], "ill legal0");
    check("ill err after legal", {31'd0, err_fmt}, 32'd0);
    send(bad_vec, "ill bad");
    check("ill err pulse", {31'd0, err_fmt}, 32'd1);
    tick();
    check("ill err clear", {31'd0, err_fmt}, 32'd0);
    send(vecs[4], "ill legal1");
    pop_check(vecs[3].exp, 8'd0, "ill pop0");
    pop_check(vecs[4].exp, 8'd1, "ill pop1");

    // start flushes the buffer and ignores a same-cycle tuple
    pulse_start();
    send(vecs[5], "flush send");
    drive(vecs[6]);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    send(vecs[7], "flush after");
    pop_check(vecs[7].exp, 8'd0, "flush pop");

    // async reset with two words buffered
    pulse_start();
    send(vecs[0], "rst send0");
    send(vecs[1], "rst send1");
    #3 reset = 1'b1;
    #1;
    check("rst async out_valid", {31'd0, out_valid}, 32'd0);
    check("rst async out_word", out_word, 32'd0);
    check("rst async in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst after out_valid", {31'd0, out_valid}, 32'd0);
    pulse_start();
    send(vecs[2], "rst resend");
    pop_check(vecs[2].exp, 8'd0, "rst pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
